// File: rtl/mult_bcd_conv.sv
// mult_bcd_conv: sequential binary-to-BCD converter (shift-and-add-3).
// It captures `bin` when `start` is accepted in IDLE and then shifts one bit
// per cycle for W_IN cycles. It presents the BCD digits on `bcd` and pulses
// `done` for one cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   start - conversion request, sampled only in IDLE
//   bin   - binary input (W_IN bits), captured on accepted start
//   busy  - high while in SHIFT or DONE
//   done  - one-cycle pulse: bcd holds a new result
//   bcd   - N_DIG packed BCD digits, most significant first
module mult_bcd_conv #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned N_DIG = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [W_IN-1:0]      bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_DIG-1:0]   bcd
);

  localparam int unsigned CW = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int unsigned DW = 4 * N_DIG;
  localparam int unsigned RW = DW + W_IN;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] work;
  logic [RW-1:0] work_adj;
  logic [RW-1:0] work_shift;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(W_IN - 1));

  // Every digit is corrected from its pre-shift value. The register is then
  // shifted, so carries move between digits only through the shift.
  always_comb begin
    work_adj = work;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (work[W_IN + 4*i +: 4] >= 4'd5)
        work_adj[W_IN + 4*i +: 4] = work[W_IN + 4*i +: 4] + 4'd3;
    end
    work_shift = {work_adj[RW-2:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state flops
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE:    ;
      SHIFT:   busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: working register, bit counter, result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      bcd  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            work <= {{DW{1'b0}}, bin};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          work <= work_shift;
          cnt  <= cnt + 1'b1;
          if (last) bcd <= work_shift[RW-1:W_IN];
        end
        default: ;
      endcase
    end
  end

endmodule
